// File: rtl/dino_frame_sequencer_if.sv
// ROM fetch and composed-row display bus of the dinosaur frame sequencer.
// master = sequencer, slave = ROMs plus display sink.
interface dino_frame_sequencer_if #(
  parameter int WIDTH  = 80,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] dino_addr;
  logic [ADDR_W-1:0] cactus_addr;
  logic [WIDTH-1:0]  dino_row;
  logic [WIDTH-1:0]  cactus_row;
  logic [WIDTH-1:0]  row_out;
  logic              row_valid;
  logic [ADDR_W-1:0] row_idx;
  logic              frame_done;

  modport master (
    output dino_addr, cactus_addr,
    input  dino_row, cactus_row,
    output row_out, row_valid, row_idx, frame_done
  );

  modport slave (
    input  dino_addr, cactus_addr,
    output dino_row, cactus_row,
    input  row_out, row_valid, row_idx, frame_done
  );
endinterface

// File: rtl/dino_frame_sequencer.sv
// Dinosaur game frame controller: row scan, ROM addressing, row
// composition, and per-frame jump/scroll/score/collision update.
module dino_frame_sequencer #(
  parameter int WIDTH       = 80,
  parameter int ROWS        = 41,
  parameter int ADDR_W      = 6,
  parameter int JUMP_H      = 12,
  parameter int HOLD_FRAMES = 4,
  parameter int SCROLL_STEP = 2
) (
  input  logic        cnt,
  input  logic        rst,
  input  logic        jump,
  input  logic        start,
  output logic        game_over,
  output logic [15:0] score,
  dino_frame_sequencer_if.master bus
);
  localparam int CXW = $clog2(WIDTH);
  localparam int HW  = $clog2(HOLD_FRAMES + 1);

  localparam logic RUN  = 1'b0;
  localparam logic OVER = 1'b1;

  localparam logic [1:0] GROUND = 2'd0;
  localparam logic [1:0] RISE   = 2'd1;
  localparam logic [1:0] HOLD   = 2'd2;
  localparam logic [1:0] FALL   = 2'd3;

  logic [ADDR_W-1:0] scan;
  logic [ADDR_W-1:0] dy;
  logic [CXW-1:0]    cx;
  logic [HW-1:0]     holdCnt;
  logic [1:0]        jumpSt;
  logic              gameSt;
  logic              jumpPend;
  logic              startPend;
  logic              hitFlag;

  logic              validQ;
  logic              blankQ;
  logic              lastQ;
  logic [ADDR_W-1:0] idxQ;
  logic [CXW-1:0]    cxQ;

  logic              updSlot;
  logic [ADDR_W:0]   dSum;
  logic              blank;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]  rot;
  logic [WIDTH-1:0]  dinoM;
  logic              hitNow;
  logic              jp;
  logic              sp;
  logic              hitAll;

  assign updSlot = scan == ADDR_W'(ROWS);
  assign dSum    = {1'b0, scan} + {1'b0, dy};
  assign blank   = dSum >= (ADDR_W+1)'(ROWS);

  always_comb begin
    bus.cactus_addr = updSlot ? '0 : scan;
    bus.dino_addr   = (updSlot || blank) ? '0 : dSum[ADDR_W-1:0];
  end

  // Upper half of the doubled row is the left rotation with wrap.
  assign dbl    = {bus.cactus_row, bus.cactus_row} << cxQ;
  assign rot    = dbl[2*WIDTH-1:WIDTH];
  assign dinoM  = blankQ ? '0 : bus.dino_row;
  assign hitNow = validQ && (|(dinoM & rot));

  assign jp     = jumpPend | jump;
  assign sp     = startPend | start;
  assign hitAll = hitFlag | hitNow;

  assign game_over = gameSt == OVER;

  always_ff @(posedge cnt) begin
    if (!rst) begin
      scan           <= '0;
      dy             <= '0;
      cx             <= '0;
      holdCnt        <= '0;
      jumpSt         <= GROUND;
      gameSt         <= RUN;
      jumpPend       <= 1'b0;
      startPend      <= 1'b0;
      hitFlag        <= 1'b0;
      score          <= '0;
      validQ         <= 1'b0;
      blankQ         <= 1'b0;
      lastQ          <= 1'b0;
      idxQ           <= '0;
      cxQ            <= '0;
      bus.row_out    <= '0;
      bus.row_valid  <= 1'b0;
      bus.row_idx    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      scan   <= updSlot ? '0 : scan + ADDR_W'(1);
      validQ <= !updSlot;
      blankQ <= blank;
      lastQ  <= scan == ADDR_W'(ROWS - 1);
      idxQ   <= scan;
      cxQ    <= cx;

      bus.row_out    <= dinoM | rot;
      bus.row_valid  <= validQ;
      bus.row_idx    <= idxQ;
      bus.frame_done <= validQ && lastQ;

      if (!updSlot) begin
        if (jump)   jumpPend  <= 1'b1;
        if (start)  startPend <= 1'b1;
        if (hitNow) hitFlag   <= 1'b1;
      end else begin
        jumpPend  <= 1'b0;
        startPend <= 1'b0;
        hitFlag   <= 1'b0;
        unique case (1'b1)
          (gameSt == RUN) && hitAll: gameSt <= OVER;
          (gameSt == RUN) && !hitAll: begin
            if (score != 16'hFFFF) score <= score + 16'd1;
            if (cx >= CXW'(WIDTH - SCROLL_STEP))
              cx <= cx - CXW'(WIDTH - SCROLL_STEP);
            else
              cx <= cx + CXW'(SCROLL_STEP);
            case (jumpSt)
              GROUND: if (jp) begin
                jumpSt <= RISE;
                dy     <= ADDR_W'(1);
              end
              RISE: begin
                dy <= dy + ADDR_W'(1);
                if (dy == ADDR_W'(JUMP_H - 1)) begin
                  jumpSt  <= HOLD;
                  holdCnt <= '0;
                end
              end
              HOLD: begin
                if (holdCnt == HW'(HOLD_FRAMES - 1)) begin
                  jumpSt  <= FALL;
                  holdCnt <= '0;
                end else begin
                  holdCnt <= holdCnt + HW'(1);
                end
              end
              default: begin
                dy <= dy - ADDR_W'(1);
                if (dy == ADDR_W'(1)) jumpSt <= GROUND;
              end
            endcase
          end
          gameSt == OVER: if (sp) begin
            gameSt  <= RUN;
            score   <= '0;
            dy      <= '0;
            cx      <= '0;
            holdCnt <= '0;
            jumpSt  <= GROUND;
          end
        endcase
      end
    end
  end
endmodule
